// File: rtl/shape_write_pkg.sv
// Shared types and constants for the shape register write sequencer.
// Optional feature macro: UART_CHECKSUM_EN (adds the CHECK state and XOR byte).
package shape_write_pkg;

    localparam int         PAYLOAD_BYTES     = 5;
    localparam int         FIELD_W           = 12;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Frame decoder states; CHECK only exists when the checksum byte is expected
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
`ifdef UART_CHECKSUM_EN
        ST_CHECK   = 2'd2,
`endif
        ST_ISSUE   = 2'd3
    } state_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
module byte_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is only meaningful while the owner is waiting for a byte
    assign expire = en && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise count up and hold at the last value
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shape_write_ctrl.sv
// Frame decoder and write sequencer: hunts for SYNC_BYTE, packs the five
// payload bytes into shape/register/data fields and issues one handshaked write.
// Optional feature macro: UART_CHECKSUM_EN (XOR checksum byte after B4).
module shape_write_ctrl
    import shape_write_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [FIELD_W-1:0] wr_shape_addr,
    output logic [FIELD_W-1:0] wr_reg_addr,
    output logic [FIELD_W-1:0] wr_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun,
    output logic [15:0]        frame_count
);

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [FIELD_W-1:0] shape_addr_q, shape_addr_d;
    logic [FIELD_W-1:0] reg_addr_q, reg_addr_d;
    logic [FIELD_W-1:0] data_q, data_d;
    logic               wr_valid_q, wr_valid_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               tmr_clr, tmr_en, tmr_expire;
`ifdef UART_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    // Next-state, field assembly, timer control and registered-output values
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shape_addr_d  = shape_addr_q;
        reg_addr_d    = reg_addr_q;
        data_d        = data_q;
        frame_err_d   = 1'b0;
        overrun_d     = 1'b0;
        frame_count_d = frame_count_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
`ifdef UART_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    tmr_clr = 1'b1;
`ifdef UART_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            ST_COLLECT: begin
                tmr_en = 1'b1;
                // A byte arriving on the expiry cycle still counts
                if (rx_valid) begin
                    tmr_clr = 1'b1;
`ifdef UART_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                    case (idx_q)
                        3'd0: shape_addr_d[11:4] = rx_data;
                        3'd1: begin
                            shape_addr_d[3:0] = rx_data[7:4];
                            reg_addr_d[11:8]  = rx_data[3:0];
                        end
                        3'd2: reg_addr_d[7:0] = rx_data;
                        3'd3: data_d[11:4]    = rx_data;
                        default: data_d[3:0]  = rx_data[7:4];
                    endcase
                    if (idx_q == LAST_IDX) begin
`ifdef UART_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_ISSUE;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (tmr_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

`ifdef UART_CHECKSUM_EN
            ST_CHECK: begin
                tmr_en = 1'b1;
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = ST_ISSUE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (tmr_expire) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
`endif

            ST_ISSUE: begin
                // The store owns the handshake; incoming bytes have nowhere to go
                overrun_d = rx_valid;
                if (wr_ready) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        wr_valid_d = (state_d == ST_ISSUE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            shape_addr_q  <= '0;
            reg_addr_q    <= '0;
            data_q        <= '0;
            wr_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shape_addr_q  <= shape_addr_d;
            reg_addr_q    <= reg_addr_d;
            data_q        <= data_d;
            wr_valid_q    <= wr_valid_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef UART_CHECKSUM_EN
    // Running XOR of the payload bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign wr_shape_addr = shape_addr_q;
    assign wr_reg_addr   = reg_addr_q;
    assign wr_data       = data_q;
    assign wr_valid      = wr_valid_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
    assign frame_count   = frame_count_q;

endmodule

// File: doc/shape_write_ctrl.md
# shape_write_ctrl

Frame decoder and write sequencer between the UART byte receiver and the shape register store. It hunts for a sync byte, assembles the following payload into a 12-bit shape address, 12-bit register address and 12-bit data word, then issues a single write with a valid/ready handshake. It also enforces an inter-byte timeout, reports framing errors and dropped bytes, and counts completed writes.

## Interface
- `TIMEOUT_CYCLES`, default 100000: max clk cycles between payload bytes before the frame is abandoned; must be ≥2.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte; valid only when `rx_valid` is high.
- `rx_valid` in 1: single-cycle strobe, one per byte.
- `wr_shape_addr` out 12: shape index of the pending write.
- `wr_reg_addr` out 12: register index within the shape.
- `wr_data` out 12: write data.
- `wr_valid` out 1: write request; held until accepted.
- `wr_ready` in 1: store accepts the write when high together with `wr_valid`.
- `busy` out 1: high in any state other than IDLE.
- `frame_err` out 1: one-cycle pulse on timeout or checksum mismatch.
- `overrun` out 1: one-cycle pulse when a byte is dropped during ISSUE.
- `frame_count` out 16: completed writes; wraps from 16'hFFFF to 0.

## Operation
- States: IDLE, COLLECT, CHECK (present only with the macro), ISSUE.
- IDLE: if `rx_valid` and `rx_data==SYNC_BYTE`, go to COLLECT with byte index 0. All other bytes are ignored silently.
- COLLECT: store payload bytes B0..B4 in order. After B4: go to CHECK if checksum is enabled, otherwise ISSUE. A SYNC_BYTE value inside the payload is data; there is no resync.
- Packing: `wr_shape_addr={B0,B1[7:4]}`, `wr_reg_addr={B1[3:0],B2}`, `wr_data={B3,B4[7:4]}`. B4[3:0] is reserved and ignored.
- Timeout: the counter clears on entry to COLLECT and on every accepted byte. It counts while in COLLECT or CHECK. When it reaches `TIMEOUT_CYCLES-1` with no byte that cycle: pulse `frame_err`, go to IDLE.
- Simultaneous byte and timeout expiry: the byte is accepted and the counter clears.
- ISSUE: `wr_valid=1`; the fields stay stable until `wr_valid&&wr_ready`. On that cycle, `frame_count` increments and the next state is IDLE. There is no timeout in ISSUE.
- Any `rx_valid` while in ISSUE, including the handshake cycle, drops the byte and pulses `overrun`.
- Reset values: state IDLE; all outputs 0; `frame_count` 0. Reset mid-frame or mid-ISSUE drops the frame immediately, with no error pulse.

## Timing
- `wr_valid` rises on the cycle after the last accepted frame byte: B4, or the checksum byte if enabled.
- With `wr_ready` held high, `wr_valid` is high for exactly one cycle. `busy` falls the cycle after the handshake.
- Minimum frame-to-frame spacing: a sync byte arriving the cycle after the handshake is recognised.
- All outputs are registered. There is no combinational path from `rx_*` or `wr_ready` to any output.
- `frame_err` and `overrun` fire the cycle after their cause is sampled.

## Configuration
- `UART_CHECKSUM_EN` defined: one extra byte C follows B4. CHECK state waits for C under the same timeout rule.
  - `C == B0^B1^B2^B3^B4`: go to ISSUE.
  - Otherwise: pulse `frame_err`, go to IDLE, no write.
- Not defined: CHECK state and the XOR accumulator are not built. The frame is sync plus 5 bytes.

## Structure
- Package `shape_write_pkg`: state enum, `PAYLOAD_BYTES=5`, field width constant (12), default `SYNC_BYTE`.
- Sub-module `byte_timeout_timer`: clear/enable inputs, expire output, `TIMEOUT_CYCLES` parameter, counter width from `$clog2`.

## Test plan
- Send A5 12 34 56 78 90 (checksum build adds 98), `wr_ready=1` -> one write, shape 0x123, reg 0x456, data 0x789; `frame_count` = 1.
- Send the same frame with `wr_ready=0` for 10 cycles; during the stall send a byte 0x55 -> `wr_valid` held with stable fields; `overrun` pulses once; write completes when `wr_ready` rises.
- Send A5 12 34, then idle for `TIMEOUT_CYCLES` -> `frame_err` pulse, state IDLE, no write; the next full frame decodes correctly.
- Send bytes 00 FF 5A before A5 plus a frame -> leading bytes ignored; exactly one write.
- Checksum build: send A5 12 34 56 78 90 99 -> `frame_err`, no write, `frame_count` unchanged.
- Preload `frame_count` to 16'hFFFF by 65535 writes (or force), then one more frame -> wraps to 0. Assert `rst_n` low mid-COLLECT -> all outputs 0, no pulse.
